// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the divided-clock ratio detector.
package freq_meas_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_e;

   localparam int unsigned LOCK_COUNT_MIN = 1;
   localparam int unsigned LOCK_COUNT_MAX = 7;

   function automatic int unsigned maxp(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic bit lock_count_ok(input int unsigned lc);
      return (lc >= LOCK_COUNT_MIN) && (lc <= LOCK_COUNT_MAX);
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes sig_in into the clk domain and flags its rising edge.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic sig_s,
   output logic rise
);

   logic sig_s_d_q;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sig_s = sig_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= sig_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end
         assign sig_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) sig_s_d_q <= 1'b0;
      else     sig_s_d_q <= sig_s;
   end

   assign rise = sig_s & ~sig_s_d_q;

endmodule

// File: rtl/freq_ratio_detector.sv
// Measures period and high time of a divided clock, with lock and sticky timeout.
// state | meaning
// IDLE  | waiting for the first rising edge (no measurement from it)
// MEAS  | counting clk cycles between consecutive rising edges
module freq_ratio_detector
   import freq_meas_pkg::*;
#(
   parameter int W           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         sig_in,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time,
   output logic         meas_valid,
   output logic         locked,
   output logic         timeout
);

   localparam logic [W-1:0] MAXP = W'(maxp(W));
   // Out-of-range LOCK_COUNT falls back to the default threshold.
   localparam logic [2:0] LOCK_TH = lock_count_ok(LOCK_COUNT) ? 3'(LOCK_COUNT - 1) : 3'd1;

   logic sig_s, rise;

   state_e       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
   logic [W-1:0] period_q, period_d, high_q, high_d;
   logic         valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
   logic [2:0]   mc_q, mc_d;
   logic         have_q, have_d;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .sig_s  (sig_s),
      .rise   (rise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         mc_q      <= '0;
         have_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
         mc_q      <= mc_d;
         have_q    <= have_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (rise) state_d = MEAS;
            MEAS:    if (!rise && cnt_q == MAXP) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      mc_d      = mc_q;
      have_d    = have_q;
      if (!en) begin
         locked_d = 1'b0;
         mc_d     = '0;
         have_d   = 1'b0;
      end else if (state_q == IDLE) begin
         if (rise) begin
            cnt_d  = W'(1);
            hcnt_d = W'(1);
            have_d = 1'b0;
         end
      end else if (rise) begin
         // A rise at cnt==MAXP is still a valid MAXP-cycle period.
         period_d  = cnt_q;
         high_d    = hcnt_q;
         valid_d   = 1'b1;
         cnt_d     = W'(1);
         hcnt_d    = W'(1);
         timeout_d = 1'b0;
         if (cnt_q != period_q)   mc_d = '0;
         else if (mc_q != 3'd7)   mc_d = mc_q + 3'd1;
         have_d    = 1'b1;
         locked_d  = have_q && (mc_d >= LOCK_TH);
      end else if (cnt_q == MAXP) begin
         timeout_d = 1'b1;
         locked_d  = 1'b0;
         mc_d      = '0;
         have_d    = 1'b0;
      end else begin
         cnt_d  = cnt_q + W'(1);
         hcnt_d = hcnt_q + W'(sig_s);
      end
   end

   always_comb begin
      period     = period_q;
      high_time  = high_q;
      meas_valid = valid_q;
      locked     = locked_q;
      timeout    = timeout_q;
   end

endmodule

// File: tb/tb_freq_ratio_detector.sv
// Scoreboard bench: two detectors (2-stage and unsynchronized input) share one stimulus.
module tb_freq_ratio_detector;

   logic       clk = 1'b0;
   logic       rst, en, sig_in;
   logic [3:0] p2, h2, p0, h0;
   logic       v2, l2, t2, v0, l0, t0;

   always #5 clk = ~clk;

   freq_ratio_detector #(.W(4), .SYNC_STAGES(2), .LOCK_COUNT(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
      .period(p2), .high_time(h2), .meas_valid(v2), .locked(l2), .timeout(t2)
   );

   freq_ratio_detector #(.W(4), .SYNC_STAGES(0), .LOCK_COUNT(2)) dut0 (
      .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
      .period(p0), .high_time(h0), .meas_valid(v0), .locked(l0), .timeout(t0)
   );

   typedef struct {
      bit is_to;
      int p;
      int h;
      int l;
   } exp_t;

   exp_t q2[$];
   exp_t q0[$];
   int   v0cyc[$];
   int   vectors = 0;
   int   errs = 0;
   int   cyc = 0;
   int   last_v[2] = '{0, 0};
   bit   to_prev[2] = '{1'b0, 1'b0};

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pv(input int p, input int h, input int l);
      exp_t e;
      e = '{1'b0, p, h, l};
      q2.push_back(e);
      q0.push_back(e);
   endtask

   task automatic pto(input int p);
      exp_t e;
      e = '{1'b1, p, 0, 0};
      q2.push_back(e);
      q0.push_back(e);
   endtask

   task automatic mon(input int d, input logic v, input logic [3:0] p, input logic [3:0] h,
                      input logic lk, input logic to);
      exp_t e;
      bit   ok;
      string tag;
      tag = (d == 0) ? "sync0" : "sync2";
      if (v === 1'b1) begin
         ok = (d == 0) ? (q0.size() > 0 && !q0[0].is_to) : (q2.size() > 0 && !q2[0].is_to);
         if (!ok) begin
            cmp({tag, "_unexpected_valid"}, 1, 0);
         end else begin
            e = (d == 0) ? q0.pop_front() : q2.pop_front();
            cmp({tag, "_period"}, 32'(p), e.p);
            cmp({tag, "_high_time"}, 32'(h), e.h);
            cmp({tag, "_locked"}, 32'(lk), e.l);
            cmp({tag, "_timeout_clr"}, 32'(to), 0);
            last_v[d] = cyc;
            if (d == 0) v0cyc.push_back(cyc);
            else if (v0cyc.size() == 0) cmp("valid_offset_missing", 1, 0);
            else cmp("valid_offset", cyc - v0cyc.pop_front(), 2);
         end
      end
      if (to === 1'b1 && !to_prev[d]) begin
         ok = (d == 0) ? (q0.size() > 0 && q0[0].is_to) : (q2.size() > 0 && q2[0].is_to);
         if (!ok) begin
            cmp({tag, "_unexpected_timeout"}, 1, 0);
         end else begin
            e = (d == 0) ? q0.pop_front() : q2.pop_front();
            cmp({tag, "_to_period_hold"}, 32'(p), e.p);
            cmp({tag, "_to_locked"}, 32'(lk), 0);
            cmp({tag, "_to_delay"}, cyc - last_v[d], 15);
         end
      end
      to_prev[d] = (to === 1'b1);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      mon(0, v0, p0, h0, l0, t0);
      mon(1, v2, p2, h2, l2, t2);
   end

   task automatic tick(input logic s);
      @(negedge clk);
      sig_in = s;
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         repeat (hi) tick(1'b1);
         repeat (lo) tick(1'b0);
      end
   endtask

   task automatic chk_hold(input string name, input int p, input int h, input int to);
      cmp({name, "_period"}, 32'(p2), p);
      cmp({name, "_high_time"}, 32'(h2), h);
      cmp({name, "_valid"}, 32'(v2), 0);
      cmp({name, "_locked"}, 32'(l2), 0);
      cmp({name, "_timeout"}, 32'(t2), to);
      cmp({name, "_period_s0"}, 32'(p0), p);
      cmp({name, "_locked_s0"}, 32'(l0), 0);
      cmp({name, "_timeout_s0"}, 32'(t0), to);
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      sig_in = 1'b0;
      repeat (3) @(posedge clk);
      #2 chk_hold("reset", 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      en = 1'b1;
      repeat (3) tick(1'b0);

      // N=4, then N=5, then N=6
      pv(4, 2, 0); pv(4, 2, 1); pv(4, 2, 1);
      wave(2, 2, 4);
      pv(4, 2, 1); pv(5, 2, 0); pv(5, 2, 1);
      wave(2, 3, 3);
      pv(5, 2, 1); pv(6, 2, 0); pv(6, 2, 1);
      wave(2, 4, 3);

      // Stop toggling, then resume
      pto(6);
      repeat (20) tick(1'b0);
      pv(6, 2, 0); pv(6, 2, 1);
      wave(2, 4, 3);

      // Period 15 is measurable, period 16 times out
      pv(6, 2, 1); pv(15, 7, 0); pv(15, 7, 1);
      wave(7, 8, 3);
      pv(15, 7, 1); pto(15);
      wave(8, 8, 2);

      // Reset in the middle of a period
      pv(4, 2, 0);
      wave(2, 2, 2);
      repeat (3) tick(1'b0);
      @(negedge clk);
      rst = 1'b1;
      sig_in = 1'b0;
      @(posedge clk);
      #2 chk_hold("mid_reset", 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) tick(1'b0);
      pv(4, 2, 0); pv(4, 2, 1); pv(4, 2, 1);
      wave(2, 2, 4);

      // Enable dropped for one cycle mid-period
      repeat (2) tick(1'b0);
      @(negedge clk);
      en = 1'b0;
      sig_in = 1'b0;
      @(posedge clk);
      #2 chk_hold("en_drop", 4, 2, 0);
      @(negedge clk);
      en = 1'b1;
      tick(1'b0);
      pv(4, 2, 0); pv(4, 2, 1);
      wave(2, 2, 3);
      pto(4);
      repeat (20) tick(1'b0);

      repeat (5) tick(1'b0);
      cmp("sync2_queue_drained", q2.size(), 0);
      cmp("sync0_queue_drained", q0.size(), 0);
      cmp("offset_queue_drained", v0cyc.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
